// File: rtl/stbuf_drain_pkg.sv
// Shared store-buffer types: entry layout, access-size codes, size-to-length decode.
// Used by the store buffer, the TCM write side and the LSU load-check side.
// Pure types and a combinational helper; no state.
package stbuf_drain_pkg;

  localparam int ADDR_WIDTH     = 32;
  localparam int SIZE_WIDTH     = 2;
  localparam int REG_DATA_WIDTH = 32;

  localparam logic [SIZE_WIDTH-1:0] SIZE_BYTE = 2'b00;
  localparam logic [SIZE_WIDTH-1:0] SIZE_HALF = 2'b01;
  localparam logic [SIZE_WIDTH-1:0] SIZE_WORD = 2'b10;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]     addr;
    logic [SIZE_WIDTH-1:0]     size;
    logic [REG_DATA_WIDTH-1:0] data;
  } stbuf_entry_t;

  // Byte length of an access; the unused code 11 is treated as a word.
  function automatic logic [2:0] size_to_len(input logic [SIZE_WIDTH-1:0] size);
    case (size)
      SIZE_BYTE: size_to_len = 3'd1;
      SIZE_HALF: size_to_len = 3'd2;
      default:   size_to_len = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/stbuf_overlap_check.sv
// Byte-range overlap test between one store-buffer entry and a pending load.
// Latency: purely combinational.  Backpressure: none, no handshake.
// Ports: entry_valid/entry_addr/entry_size describe the queued store,
//        load_addr/load_size the load, hit = valid entry overlaps the load.
module stbuf_overlap_check
  import stbuf_drain_pkg::*;
(
  input  logic                  entry_valid,
  input  logic [ADDR_WIDTH-1:0] entry_addr,
  input  logic [SIZE_WIDTH-1:0] entry_size,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [SIZE_WIDTH-1:0] load_size,
  output logic                  hit
);

  localparam int EXT_WIDTH = ADDR_WIDTH + 1;

  // Range ends carry one extra bit so a range touching the top of the
  // address space does not wrap around to zero and falsely overlap.
  logic [ADDR_WIDTH:0] entry_end;
  logic [ADDR_WIDTH:0] load_end;

  assign entry_end = {1'b0, entry_addr} + EXT_WIDTH'(size_to_len(entry_size));
  assign load_end  = {1'b0, load_addr}  + EXT_WIDTH'(size_to_len(load_size));

  assign hit = entry_valid
            && ({1'b0, load_addr}  < entry_end)
            && ({1'b0, entry_addr} < load_end);

endmodule

// File: rtl/stbuf_drain.sv
// In-order store buffer that retires committed stores to the TCM write port.
// Latency: a store pushed at edge N can be written no earlier than the cycle after N.
// Backpressure: commit ready = !full (no full-bypass); drain only while stbuf_drain_en.
// Ports: commit_stbuf_* enqueue side, bus_tcm_stbuf_* write side (wr is
//        combinational), lsu_stbuf_check_* load probe -> stbuf_lsu_conflict,
//        stbuf_empty / stbuf_count status from registered state.
module stbuf_drain
  import stbuf_drain_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst,

  input  logic                      commit_stbuf_valid,
  output logic                      stbuf_commit_ready,
  input  logic [ADDR_WIDTH-1:0]     commit_stbuf_addr,
  input  logic [SIZE_WIDTH-1:0]     commit_stbuf_size,
  input  logic [REG_DATA_WIDTH-1:0] commit_stbuf_data,

  input  logic                      stbuf_drain_en,
  output logic [ADDR_WIDTH-1:0]     bus_tcm_stbuf_write_addr,
  output logic [SIZE_WIDTH-1:0]     bus_tcm_stbuf_write_size,
  output logic [REG_DATA_WIDTH-1:0] bus_tcm_stbuf_data,
  output logic                      bus_tcm_stbuf_wr,

  input  logic [ADDR_WIDTH-1:0]     lsu_stbuf_check_addr,
  input  logic [SIZE_WIDTH-1:0]     lsu_stbuf_check_size,
  output logic                      stbuf_lsu_conflict,

  output logic                      stbuf_empty,
  output logic [CNT_WIDTH-1:0]      stbuf_count
);

  localparam int                   PTR_WIDTH  = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(DEPTH);

  stbuf_entry_t           entries [DEPTH];
  logic [DEPTH-1:0]       entry_valid;
  logic [PTR_WIDTH-1:0]   head;
  logic [PTR_WIDTH-1:0]   tail;
  logic [CNT_WIDTH-1:0]   count;

  logic                   full;
  logic                   empty;
  logic                   push;
  logic                   pop;
  stbuf_entry_t           head_entry;
  logic [DEPTH-1:0]       entry_hit;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // Ready depends only on occupancy, so a pop in the same cycle does not
  // open a slot for a push while full.
  assign stbuf_commit_ready = !full;
  assign push               = commit_stbuf_valid && !full;
  assign pop                = !empty && stbuf_drain_en;

  assign stbuf_empty = empty;
  assign stbuf_count = count;

  // Pointers and occupancy. Push and pop never target the same slot: a push
  // needs !full and a pop needs !empty, so head == tail cannot coincide here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      entry_valid <= '0;
    end else begin
      if (push) begin
        entry_valid[tail] <= 1'b1;
        tail              <= tail + 1'b1;
      end
      if (pop) begin
        entry_valid[head] <= 1'b0;
        head              <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry payload storage; contents are qualified by entry_valid and by
  // the empty gate on the bus, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      entries[tail] <= '{addr: commit_stbuf_addr,
                         size: commit_stbuf_size,
                         data: commit_stbuf_data};
    end
  end

  assign head_entry = entries[head];

  always_comb begin
    bus_tcm_stbuf_wr         = pop;
    bus_tcm_stbuf_write_addr = '0;
    bus_tcm_stbuf_write_size = '0;
    bus_tcm_stbuf_data       = '0;
    if (!empty) begin
      bus_tcm_stbuf_write_addr = head_entry.addr;
      bus_tcm_stbuf_write_size = head_entry.size;
      bus_tcm_stbuf_data       = head_entry.data;
    end
  end

  // The entry being popped this cycle still counts as a conflict: its write
  // lands at this edge, so the load must wait at least one more cycle.
  for (genvar g = 0; g < DEPTH; g++) begin : g_overlap
    stbuf_overlap_check u_overlap (
      .entry_valid (entry_valid[g]),
      .entry_addr  (entries[g].addr),
      .entry_size  (entries[g].size),
      .load_addr   (lsu_stbuf_check_addr),
      .load_size   (lsu_stbuf_check_size),
      .hit         (entry_hit[g])
    );
  end

  assign stbuf_lsu_conflict = |entry_hit;

endmodule

// File: tb/tb_stbuf_drain.sv
module tb_stbuf_drain;
  import stbuf_drain_pkg::*;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      c_valid;
  logic                      c_ready;
  logic [ADDR_WIDTH-1:0]     c_addr;
  logic [SIZE_WIDTH-1:0]     c_size;
  logic [REG_DATA_WIDTH-1:0] c_data;
  logic                      drain_en;
  logic [ADDR_WIDTH-1:0]     b_addr;
  logic [SIZE_WIDTH-1:0]     b_size;
  logic [REG_DATA_WIDTH-1:0] b_data;
  logic                      b_wr;
  logic [ADDR_WIDTH-1:0]     l_addr;
  logic [SIZE_WIDTH-1:0]     l_size;
  logic                      conflict;
  logic                      empty;
  logic [CW-1:0]             count;

  stbuf_drain #(.DEPTH(DEPTH)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .commit_stbuf_valid       (c_valid),
    .stbuf_commit_ready       (c_ready),
    .commit_stbuf_addr        (c_addr),
    .commit_stbuf_size        (c_size),
    .commit_stbuf_data        (c_data),
    .stbuf_drain_en           (drain_en),
    .bus_tcm_stbuf_write_addr (b_addr),
    .bus_tcm_stbuf_write_size (b_size),
    .bus_tcm_stbuf_data       (b_data),
    .bus_tcm_stbuf_wr         (b_wr),
    .lsu_stbuf_check_addr     (l_addr),
    .lsu_stbuf_check_size     (l_size),
    .stbuf_lsu_conflict       (conflict),
    .stbuf_empty              (empty),
    .stbuf_count              (count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Byte-addressed TCM driven purely by the DUT write port (little-endian).
  logic [7:0] tcm [0:255] = '{default: 8'h00};

  function automatic int blen(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  always @(posedge clk) begin
    if (b_wr) begin
      for (int b = 0; b < blen(b_size); b++)
        tcm[8'(b_addr + 32'(b))] <= b_data[8*b +: 8];
    end
  end

  function automatic logic [31:0] tcm_word(input int a);
    return {tcm[a+3], tcm[a+2], tcm[a+1], tcm[a]};
  endfunction

  // Reference model: an ordered queue of pending stores.
  typedef struct {
    logic [31:0] a;
    logic [1:0]  s;
    logic [31:0] d;
  } ent_t;
  ent_t q[$];

  function automatic bit ref_conflict(input logic [31:0] la, input logic [1:0] ls);
    longint lo = longint'(la);
    foreach (q[i]) begin
      longint eo = longint'(q[i].a);
      if ((lo < eo + blen(q[i].s)) && (eo < lo + blen(ls))) return 1'b1;
    end
    return 1'b0;
  endfunction

  // One clock: check all outputs mid-cycle against the model, then advance
  // the model with the handshakes that the rules say happen at the edge.
  task automatic cycle(input string tag);
    bit   exp_pop;
    bit   exp_push;
    ent_t e;
    @(negedge clk);
    chk({tag, ".count"}, count, q.size());
    chk({tag, ".empty"}, empty, q.size() == 0);
    chk({tag, ".ready"}, c_ready, q.size() < DEPTH);
    exp_pop = (q.size() > 0) && drain_en;
    chk({tag, ".wr"}, b_wr, exp_pop);
    if (q.size() > 0) begin
      chk({tag, ".addr"}, b_addr, q[0].a);
      chk({tag, ".size"}, b_size, q[0].s);
      chk({tag, ".data"}, b_data, q[0].d);
    end else begin
      chk({tag, ".addr0"}, b_addr, 0);
      chk({tag, ".data0"}, b_data, 0);
    end
    chk({tag, ".conflict"}, conflict, ref_conflict(l_addr, l_size));
    exp_push = c_valid && (q.size() < DEPTH);
    e.a = c_addr;
    e.s = c_size;
    e.d = c_data;
    @(posedge clk);
    if (exp_pop) void'(q.pop_front());
    if (exp_push) q.push_back(e);
    #1;
  endtask

  task automatic offer(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d,
                       input string tag);
    c_valid = 1'b1;
    c_addr  = a;
    c_size  = s;
    c_data  = d;
    cycle(tag);
    c_valid = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [1:0]  s;
    bit          exp;
  } probe_t;

  probe_t probes[4] = '{
    '{32'h8, 2'd2, 1'b1},
    '{32'h6, 2'd1, 1'b0},
    '{32'hF, 2'd0, 1'b0},
    '{32'hE, 2'd0, 1'b1}
  };

  logic [39:0] hi_bytes;

  initial begin
    rst      = 1'b1;
    c_valid  = 1'b0;
    c_addr   = '0;
    c_size   = '0;
    c_data   = '0;
    drain_en = 1'b0;
    l_addr   = 32'h1000;
    l_size   = 2'd0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.wr", b_wr, 0);
    chk("rst.addr", b_addr, 0);
    chk("rst.data", b_data, 0);
    chk("rst.ready", c_ready, 1);
    chk("rst.empty", empty, 1);
    chk("rst.count", count, 0);
    chk("rst.conflict", conflict, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single store, drained the following cycle
    drain_en = 1'b1;
    offer(32'h0, 2'd2, 32'h12345678, "t1.push");
    cycle("t1.drain");
    cycle("t1.idle");
    chk("t1.tcm", tcm_word(0), 32'h12345678);
    chk("t1.empty", empty, 1);

    // Fill to full with drain disabled, ninth offer refused, then drain in order
    drain_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) offer(32'(i * 4), 2'd2, 32'(i), "t2.fill");
    chk("t2.count_full", count, DEPTH);
    chk("t2.ready_full", c_ready, 0);
    offer(32'h20, 2'd2, 32'h99, "t2.ninth");
    chk("t2.count_after9", count, DEPTH);
    drain_en = 1'b1;
    for (int i = 0; i <= DEPTH; i++) cycle("t2.drain");
    for (int i = 0; i < DEPTH; i++) chk("t2.tcm", tcm_word(i * 4), i);

    // Full with drain and a continuously offered store
    drain_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) offer(32'h20 + 32'(i * 4), 2'd2, 32'h100 + 32'(i), "t3.fill");
    drain_en = 1'b1;
    c_valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      c_addr = 32'h20 + 32'(i * 4);
      c_size = 2'd2;
      c_data = 32'h200 + 32'(i);
      cycle("t3.stream");
    end
    c_valid = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) cycle("t3.drain");

    // Byte-range conflicts
    drain_en = 1'b0;
    offer(32'hA, 2'd0, 32'h11, "t4.byte");
    offer(32'hB, 2'd2, 32'h22334455, "t4.word");
    foreach (probes[k]) begin
      l_addr = probes[k].a;
      l_size = probes[k].s;
      cycle("t4.probe");
      chk("t4.conflict", conflict, probes[k].exp);
    end
    drain_en = 1'b1;
    repeat (3) cycle("t4.drain");
    l_addr = 32'h8;
    l_size = 2'd2;
    cycle("t4.after");
    chk("t4.conflict_after", conflict, 0);
    l_addr = 32'h1000;

    // Misaligned stores land at the right bytes
    offer(32'hB, 2'd2, 32'hA5CBEEAC, "t5.w0");
    offer(32'hF, 2'd0, 32'h000000CB, "t5.b");
    offer(32'h10, 2'd2, 32'hAABBCCDD, "t5.w1");
    repeat (3) cycle("t5.drain");
    hi_bytes = {tcm[15], tcm[14], tcm[13], tcm[12], tcm[11]};
    chk("t5.hi128", hi_bytes, 40'hCBA5CBEEAC);
    chk("t5.word10", tcm_word(16), 32'hAABBCCDD);

    // Asynchronous reset with stores queued and a write pending
    drain_en = 1'b0;
    for (int i = 0; i < 5; i++) offer(32'h40 + 32'(i * 4), 2'd2, 32'hDEAD0000 + 32'(i), "t6.fill");
    drain_en = 1'b1;
    @(negedge clk);
    chk("t6.wr_before", b_wr, 1);
    chk("t6.count_before", count, 5);
    #2 rst = 1'b1;
    #1;
    chk("t6.wr_async", b_wr, 0);
    chk("t6.count_async", count, 0);
    chk("t6.empty_async", empty, 1);
    chk("t6.ready_async", c_ready, 1);
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) cycle("t6.post");
    for (int i = 0; i < 5; i++) chk("t6.tcm", tcm_word(32'h40 + i * 4), 0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      c_valid  = 1'($urandom_range(0, 1));
      drain_en = ($urandom_range(0, 2) != 0);
      c_addr   = 32'($urandom_range(0, 31));
      c_size   = 2'($urandom_range(0, 3));
      c_data   = $urandom;
      l_addr   = 32'($urandom_range(0, 40));
      l_size   = 2'($urandom_range(0, 3));
      cycle("rnd");
    end
    c_valid  = 1'b0;
    drain_en = 1'b1;
    repeat (DEPTH + 2) cycle("rnd.drain");
    chk("rnd.empty_end", empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
